insn_exec_seq: RTL and testbench



---
 rtl/dpc_exec_pkg.sv | 36 +++
 rtl/insn_opcode_decoder.sv | 32 +++
 rtl/insn_exec_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_insn_exec_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpc_exec_pkg.sv
// Opcodes, sequencer state encodings and default widths shared by the execution
// sequencer and the IP/loop-lookup line.
package dpc_exec_pkg;

  localparam int AP_WIDTH_DEF   = 12;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int INSN_WIDTH_DEF = 4;

  localparam logic [INSN_WIDTH_DEF-1:0] OP_NOP        = 4'd0;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_HALT       = 4'd1;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_INC        = 4'd2;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_DEC        = 4'd3;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_AP_INC     = 4'd4;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_AP_DEC     = 4'd5;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_LOOP_OPEN  = 4'd6;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_LOOP_CLOSE = 4'd7;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_OUT        = 4'd8;
  localparam logic [INSN_WIDTH_DEF-1:0] OP_IN         = 4'd9;

  localparam int STATE_WIDTH = 4;
  typedef logic [STATE_WIDTH-1:0] exec_state_t;

  localparam exec_state_t S_INIT     = 4'd0;
  localparam exec_state_t S_IDLE     = 4'd1;
  localparam exec_state_t S_FETCH    = 4'd2;
  localparam exec_state_t S_WAIT_IP  = 4'd3;
  localparam exec_state_t S_DECODE   = 4'd4;
  localparam exec_state_t S_RD       = 4'd5;
  localparam exec_state_t S_RD_WAIT  = 4'd6;
  localparam exec_state_t S_WR       = 4'd7;
  localparam exec_state_t S_WR_WAIT  = 4'd8;
  localparam exec_state_t S_OUT_WAIT = 4'd9;
  localparam exec_state_t S_IN_WAIT  = 4'd10;
  localparam exec_state_t S_HALTED   = 4'd11;

endpackage

// File: rtl/insn_opcode_decoder.sv
// Combinational opcode classifier: one flag per instruction class; NOP and the
// unassigned codes raise no flag.
module insn_opcode_decoder
  import dpc_exec_pkg::*;
#(
  parameter int INSN_WIDTH = INSN_WIDTH_DEF
) (
  input  logic [INSN_WIDTH-1:0] insn,
  output logic                  is_cell_op,
  output logic                  is_ap_op,
  output logic                  is_io,
  output logic                  is_halt,
  output logic                  is_loop
);

  always_comb begin
    is_cell_op = 1'b0;
    is_ap_op   = 1'b0;
    is_io      = 1'b0;
    is_halt    = 1'b0;
    is_loop    = 1'b0;
    case (insn)
      OP_INC, OP_DEC:              is_cell_op = 1'b1;
      OP_AP_INC, OP_AP_DEC:        is_ap_op   = 1'b1;
      OP_OUT, OP_IN:               is_io      = 1'b1;
      OP_HALT:                     is_halt    = 1'b1;
      OP_LOOP_OPEN, OP_LOOP_CLOSE: is_loop    = 1'b1;
      default:                     is_loop    = 1'b0;
    endcase
  end

endmodule

// File: rtl/insn_exec_seq.sv
// Execution sequencer: fetches from the IP line, decodes, and runs cell/AP/I-O ops
// against data RAM. Build option STEP_EN adds a Step input for single-stepping.
module insn_exec_seq
  import dpc_exec_pkg::*;
#(
  parameter int AP_WIDTH   = AP_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int INSN_WIDTH = INSN_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst,
`ifdef STEP_EN
  input  logic                  Step,
`endif
  input  logic                  Run,
  output logic                  IpRequest,
  input  logic                  IpReady,
  input  logic [INSN_WIDTH-1:0] Insn,
  output logic                  DataZero,
  output logic [AP_WIDTH-1:0]   Ap,
  output logic                  RamReq,
  output logic                  RamWe,
  output logic [DATA_WIDTH-1:0] RamWData,
  input  logic [DATA_WIDTH-1:0] RamRData,
  input  logic                  RamReady,
  output logic                  StdoutValid,
  output logic [DATA_WIDTH-1:0] StdoutData,
  input  logic                  StdoutReady,
  input  logic                  StdinValid,
  input  logic [DATA_WIDTH-1:0] StdinData,
  output logic                  StdinAck,
  output logic                  Halted,
  output logic                  Busy
);

  exec_state_t           state_q, state_d;
  logic                  wait_armed_q, wait_armed_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic [DATA_WIDTH-1:0] cell_q, cell_d;
  logic [AP_WIDTH-1:0]   ap_q, ap_d;
  logic                  data_zero_q, data_zero_d;
  logic                  ip_request_q, ip_request_d;
  logic                  ram_req_q, ram_req_d;
  logic                  ram_we_q, ram_we_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  stdout_valid_q, stdout_valid_d;
  logic [DATA_WIDTH-1:0] stdout_data_q, stdout_data_d;
  logic                  stdin_ack_q, stdin_ack_d;
  logic                  halted_q, halted_d;
  logic                  busy_q, busy_d;

  logic is_cell_op, is_ap_op, is_io, is_halt, is_loop;
  logic go;

  insn_opcode_decoder #(
    .INSN_WIDTH (INSN_WIDTH)
  ) u_dec (
    .insn       (insn_q),
    .is_cell_op (is_cell_op),
    .is_ap_op   (is_ap_op),
    .is_io      (is_io),
    .is_halt    (is_halt),
    .is_loop    (is_loop)
  );

`ifdef STEP_EN
  logic step_q;
  logic step_pend_q, step_pend_d;
  logic step_rise;

  // A rising edge seen while busy is remembered so no step request is lost.
  assign step_rise = Step & ~step_q;
  assign go        = step_pend_q | step_rise;

  always_comb begin
    step_pend_d = step_pend_q | step_rise;
    if ((state_q == S_IDLE) && go) begin
      step_pend_d = 1'b0;
    end else begin
      step_pend_d = step_pend_q | step_rise;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      step_q      <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_q      <= Step;
      step_pend_q <= step_pend_d;
    end
  end
`else
  assign go = Run;
`endif

  always_comb begin
    state_d        = state_q;
    wait_armed_d   = wait_armed_q;
    insn_d         = insn_q;
    cell_d         = cell_q;
    ap_d           = ap_q;
    stdout_valid_d = stdout_valid_q;
    stdout_data_d  = stdout_data_q;
    stdin_ack_d    = 1'b0;
    halted_d       = halted_q;
    ram_wdata_d    = ram_wdata_q;

    case (state_q)
      S_INIT: begin
        state_d = S_RD;
      end
      S_IDLE: begin
        if (go) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        wait_armed_d = 1'b0;
        state_d      = S_WAIT_IP;
      end
      S_WAIT_IP: begin
        // IpReady still reflects the previous instruction for one cycle after the pulse.
        if (!wait_armed_q) begin
          wait_armed_d = 1'b1;
        end else if (IpReady) begin
          insn_d  = Insn;
          state_d = S_DECODE;
        end else begin
          state_d = S_WAIT_IP;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else if (is_cell_op) begin
          if (insn_q == OP_DEC) begin
            cell_d = cell_q - DATA_WIDTH'(1);
          end else begin
            cell_d = cell_q + DATA_WIDTH'(1);
          end
          state_d = S_WR;
        end else if (is_ap_op) begin
          if (insn_q == OP_AP_DEC) begin
            ap_d = ap_q - AP_WIDTH'(1);
          end else begin
            ap_d = ap_q + AP_WIDTH'(1);
          end
          state_d = S_RD;
        end else if (is_io) begin
          if (insn_q == OP_IN) begin
            state_d = S_IN_WAIT;
          end else begin
            stdout_valid_d = 1'b1;
            stdout_data_d  = cell_q;
            state_d        = S_OUT_WAIT;
          end
        end else if (is_loop) begin
          // The IP line already chose the branch target from DataZero.
          state_d = S_IDLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (RamReady) begin
          cell_d  = RamRData;
          state_d = S_IDLE;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_WR: begin
        state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (RamReady) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WR_WAIT;
        end
      end
      S_OUT_WAIT: begin
        if (StdoutReady) begin
          stdout_valid_d = 1'b0;
          state_d        = S_IDLE;
        end else begin
          state_d = S_OUT_WAIT;
        end
      end
      S_IN_WAIT: begin
        if (StdinValid) begin
          cell_d      = StdinData;
          stdin_ack_d = 1'b1;
          state_d     = S_WR;
        end else begin
          state_d = S_IN_WAIT;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    // Strobes are derived from the next state so each registered pulse lines up
    // with the cycle spent in the state that owns it.
    ip_request_d = (state_d == S_FETCH);
    ram_req_d    = (state_d == S_RD) || (state_d == S_WR);
    ram_we_d     = (state_d == S_WR);
    if (state_d == S_WR) begin
      ram_wdata_d = cell_d;
    end else begin
      ram_wdata_d = ram_wdata_q;
    end
    data_zero_d = (cell_d == '0);
    busy_d      = (state_d != S_IDLE) && (state_d != S_HALTED);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= S_INIT;
      wait_armed_q   <= 1'b0;
      insn_q         <= '0;
      cell_q         <= '0;
      ap_q           <= '0;
      data_zero_q    <= 1'b1;
      ip_request_q   <= 1'b0;
      ram_req_q      <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_wdata_q    <= '0;
      stdout_valid_q <= 1'b0;
      stdout_data_q  <= '0;
      stdin_ack_q    <= 1'b0;
      halted_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_armed_q   <= wait_armed_d;
      insn_q         <= insn_d;
      cell_q         <= cell_d;
      ap_q           <= ap_d;
      data_zero_q    <= data_zero_d;
      ip_request_q   <= ip_request_d;
      ram_req_q      <= ram_req_d;
      ram_we_q       <= ram_we_d;
      ram_wdata_q    <= ram_wdata_d;
      stdout_valid_q <= stdout_valid_d;
      stdout_data_q  <= stdout_data_d;
      stdin_ack_q    <= stdin_ack_d;
      halted_q       <= halted_d;
      busy_q         <= busy_d;
    end
  end

  assign IpRequest   = ip_request_q;
  assign DataZero    = data_zero_q;
  assign Ap          = ap_q;
  assign RamReq      = ram_req_q;
  assign RamWe       = ram_we_q;
  assign RamWData    = ram_wdata_q;
  assign StdoutValid = stdout_valid_q;
  assign StdoutData  = stdout_data_q;
  assign StdinAck    = stdin_ack_q;
  assign Halted      = halted_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_insn_exec_seq.sv
// Bench for insn_exec_seq: instruction table plus hand sequences, with RAM/IP/stdio
// models and a scoreboard of expected RAM accesses and output bytes.
module tb_insn_exec_seq;
  import dpc_exec_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Run = 1'b0;
  logic        IpRequest;
  logic        IpReady = 1'b1;
  logic [3:0]  Insn = OP_HALT;
  logic        DataZero;
  logic [11:0] Ap;
  logic        RamReq, RamWe;
  logic [7:0]  RamWData;
  logic [7:0]  RamRData = 8'h00;
  logic        RamReady = 1'b0;
  logic        StdoutValid;
  logic [7:0]  StdoutData;
  logic        StdoutReady = 1'b1;
  logic        StdinValid = 1'b1;
  logic [7:0]  StdinData = 8'h3C;
  logic        StdinAck, Halted, Busy;

  always #5 Clk = ~Clk;

  insn_exec_seq dut (
    .Clk(Clk), .Rst(Rst), .Run(Run), .IpRequest(IpRequest), .IpReady(IpReady),
    .Insn(Insn), .DataZero(DataZero), .Ap(Ap), .RamReq(RamReq), .RamWe(RamWe),
    .RamWData(RamWData), .RamRData(RamRData), .RamReady(RamReady),
    .StdoutValid(StdoutValid), .StdoutData(StdoutData), .StdoutReady(StdoutReady),
    .StdinValid(StdinValid), .StdinData(StdinData), .StdinAck(StdinAck),
    .Halted(Halted), .Busy(Busy)
  );

  typedef struct packed { logic we; logic [11:0] addr; logic [7:0] data; } acc_t;
  typedef struct { logic [3:0] op; logic [11:0] ap; logic dz; int lat; } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          ip_cnt = 0;
  int          out_cnt = 0;
  int          ack_cnt = 0;
  acc_t        exp_acc[$];
  logic [7:0]  exp_out[$];
  logic [3:0]  prog_q[$];
  logic [7:0]  ram  [0:4095];
  logic [7:0]  mref [0:4095];
  logic [7:0]  m_cell = 8'h00;
  logic [11:0] m_ap = 12'h000;
  logic        req_seen = 1'b0;
  logic [7:0]  rdata_lat = 8'h00;
  int          ip_ph = 0;
  logic        ip_toggle = 1'b0;
  vec_t        vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural reference: updates the model and queues the accesses the op implies.
  task automatic model_exec(input logic [3:0] op);
    case (op)
      OP_INC:    begin m_cell = m_cell + 8'd1; mref[m_ap] = m_cell; exp_acc.push_back({1'b1, m_ap, m_cell}); end
      OP_DEC:    begin m_cell = m_cell - 8'd1; mref[m_ap] = m_cell; exp_acc.push_back({1'b1, m_ap, m_cell}); end
      OP_AP_INC: begin m_ap = m_ap + 12'd1; exp_acc.push_back({1'b0, m_ap, 8'h00}); m_cell = mref[m_ap]; end
      OP_AP_DEC: begin m_ap = m_ap - 12'd1; exp_acc.push_back({1'b0, m_ap, 8'h00}); m_cell = mref[m_ap]; end
      OP_OUT:    exp_out.push_back(m_cell);
      OP_IN:     begin m_cell = StdinData; mref[m_ap] = m_cell; exp_acc.push_back({1'b1, m_ap, m_cell}); end
      default:   ;
    endcase
  endtask

  task automatic run_insn(input logic [3:0] op, output int lat);
    int k;
    prog_q.push_back(op);
    model_exec(op);
    Run = 1'b1;
    k = 0;
    @(negedge Clk);
    while (!IpRequest && k < 40) begin @(negedge Clk); k++; end
    Run = 1'b0;
    if (!IpRequest) chk("fetch_timeout", 32'd0, 32'd1);
    lat = 0;
    do begin @(negedge Clk); lat++; end while (Busy && lat < 200);
  endtask

  // Neighbour models (RAM, IP line, stdout sink) and the scoreboard, all on the falling edge.
  initial begin
    acc_t e;
    forever begin
      @(negedge Clk);
      RamReady = req_seen;
      if (req_seen) RamRData = rdata_lat;
      req_seen = RamReq;
      if (RamReq) begin
        if (exp_acc.size() == 0) begin
          chk("ram_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_acc.pop_front();
          chk("ram_we", 32'(RamWe), 32'(e.we));
          chk("ram_addr", 32'(Ap), 32'(e.addr));
          if (e.we) chk("ram_wdata", 32'(RamWData), 32'(e.data));
        end
        if (RamWe) ram[Ap] = RamWData;
        else rdata_lat = ram[Ap];
      end

      if (IpRequest) begin
        ip_cnt++;
        chk("busy_at_fetch", 32'(Busy), 32'd1);
      end
      // The IP line keeps its stale ready/insn for one cycle after the request.
      if (ip_toggle) begin
        IpReady = ~IpReady;
      end else if (ip_ph == 0) begin
        IpReady = 1'b1;
        if (IpRequest) ip_ph = 1;
      end else if (ip_ph == 1) begin
        ip_ph = 2;
      end else if (ip_ph == 2) begin
        IpReady = 1'b0;
        Insn = (prog_q.size() > 0) ? prog_q.pop_front() : OP_NOP;
        ip_ph = 3;
      end else begin
        IpReady = 1'b1;
        ip_ph = 0;
      end

      if (StdoutValid && StdoutReady) begin
        out_cnt++;
        if (exp_out.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
        else chk("out_data", 32'(StdoutData), 32'(exp_out.pop_front()));
      end
      if (StdinAck) ack_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    int ip_before;
    int out_before;
    for (int i = 0; i < 4096; i++) begin ram[i] = 8'h00; mref[i] = 8'h00; end
    ram[12'hFFF]  = 8'h55;
    mref[12'hFFF] = 8'h55;

    vecs[0]  = '{OP_INC,        12'h000, 1'b0, 7};
    vecs[1]  = '{OP_INC,        12'h000, 1'b0, 7};
    vecs[2]  = '{OP_INC,        12'h000, 1'b0, 7};
    vecs[3]  = '{OP_AP_DEC,     12'hFFF, 1'b0, 7};
    vecs[4]  = '{OP_OUT,        12'hFFF, 1'b0, 6};
    vecs[5]  = '{OP_AP_INC,     12'h000, 1'b0, 7};
    vecs[6]  = '{OP_AP_INC,     12'h001, 1'b1, 7};
    vecs[7]  = '{OP_DEC,        12'h001, 1'b0, 7};
    vecs[8]  = '{OP_INC,        12'h001, 1'b1, 7};
    vecs[9]  = '{OP_NOP,        12'h001, 1'b1, 5};
    vecs[10] = '{OP_LOOP_OPEN,  12'h001, 1'b1, 5};
    vecs[11] = '{4'd12,         12'h001, 1'b1, 5};
    vecs[12] = '{OP_IN,         12'h001, 1'b0, 8};
    vecs[13] = '{OP_LOOP_CLOSE, 12'h001, 1'b0, 5};
    vecs[14] = '{OP_OUT,        12'h001, 1'b0, 6};

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ipreq", 32'(IpRequest), 32'd0);
    chk("rst_datazero", 32'(DataZero), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_halted", 32'(Halted), 32'd0);
    chk("rst_ap", 32'(Ap), 32'd0);
    chk("rst_ramreq", 32'(RamReq), 32'd0);
    chk("rst_stdout_valid", 32'(StdoutValid), 32'd0);
    chk("rst_stdin_ack", 32'(StdinAck), 32'd0);

    exp_acc.push_back({1'b0, 12'h000, 8'h00});
    m_cell = mref[0];
    @(posedge Clk); #1 Rst = 1'b0;
    repeat (8) @(negedge Clk);
    chk("init_read_done", 32'(exp_acc.size()), 32'd0);
    chk("init_idle", 32'(Busy), 32'd0);
    chk("init_datazero", 32'(DataZero), 32'd1);
    chk("init_no_fetch", 32'(ip_cnt), 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_insn(vecs[i].op, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_ap", i), 32'(Ap), 32'(vecs[i].ap));
      chk($sformatf("vec%0d_datazero", i), 32'(DataZero), 32'(vecs[i].dz));
    end
    repeat (10) @(negedge Clk);
    chk("run_low_stays_idle", 32'(ip_cnt), 32'd15);

    // OUT against a stalled sink.
    @(posedge Clk); #1 StdoutReady = 1'b0;
    @(negedge Clk);
    out_before = out_cnt;
    prog_q.push_back(OP_OUT);
    model_exec(OP_OUT);
    Run = 1'b1;
    k = 0;
    while (!StdoutValid && k < 40) begin @(negedge Clk); k++; if (IpRequest) Run = 1'b0; end
    Run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(StdoutValid), 32'd1);
      chk("stall_data", 32'(StdoutData), 32'h3C);
      @(negedge Clk);
    end
    @(posedge Clk); #1 StdoutReady = 1'b1;
    k = 0;
    do begin @(negedge Clk); k++; end while (Busy && k < 40);
    chk("stall_one_transfer", 32'(out_cnt - out_before), 32'd1);
    chk("stall_valid_cleared", 32'(StdoutValid), 32'd0);
    run_insn(OP_NOP, lat);
    chk("after_out_fetch_latency", 32'(lat), 32'd5);

    // HALT is sticky against Run and IpReady activity.
    run_insn(OP_HALT, lat);
    chk("halt_latency", 32'(lat), 32'd5);
    chk("halt_flag", 32'(Halted), 32'd1);
    ip_before = ip_cnt;
    ip_toggle = 1'b1;
    for (int i = 0; i < 20; i++) begin @(negedge Clk); Run = ~Run; end
    Run = 1'b0;
    ip_toggle = 1'b0;
    @(negedge Clk);
    chk("halt_no_fetch", 32'(ip_cnt), 32'(ip_before));
    chk("halt_still", 32'(Halted), 32'd1);

    m_ap = 12'h000;
    m_cell = mref[0];
    exp_acc.push_back({1'b0, 12'h000, 8'h00});
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("rerst_halted", 32'(Halted), 32'd0);
    chk("rerst_datazero", 32'(DataZero), 32'd1);
    chk("rerst_ap", 32'(Ap), 32'd0);
    @(posedge Clk); #1 Rst = 1'b0;
    repeat (8) @(negedge Clk);
    chk("rerst_read_done", 32'(exp_acc.size()), 32'd0);
    chk("rerst_datazero_loaded", 32'(DataZero), 32'd0);
    run_insn(OP_INC, lat);
    chk("rerst_inc_latency", 32'(lat), 32'd7);

    repeat (5) @(negedge Clk);
    chk("final_acc_drained", 32'(exp_acc.size()), 32'd0);
    chk("final_out_drained", 32'(exp_out.size()), 32'd0);
    chk("final_out_count", 32'(out_cnt), 32'd3);
    chk("final_ack_count", 32'(ack_cnt), 32'd1);
    chk("final_ram0", 32'(ram[0]), 32'h04);
    chk("final_ram1", 32'(ram[1]), 32'h3C);
    chk("final_ramfff", 32'(ram[12'hFFF]), 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
